// File: rtl/nf_pkt_pkg.sv
// Shared frame layout, expected test-frame contents, FSM and class encodings
// for the RX packet checker.
package nf_pkt_pkg;

    localparam int OFF_DST  = 0;
    localparam int OFF_SRC  = 6;
    localparam int OFF_TYPE = 12;
    localparam int OFF_PAY  = 14;
    localparam int OFF_SEQ  = 22;
    localparam int MIN_LEN  = 26;

    localparam logic [47:0] EXP_DST_MAC = 48'h3ca9f457afde;
    localparam logic [47:0] EXP_SRC_MAC = 48'h3ca9f457aade;
    localparam logic [15:0] ETH_TYPE    = 16'h0800;
    localparam logic [63:0] PAYLOAD     = 64'hf00d_face_d066_f00d;

    // Header bytes 0..21 in wire order, padded to 32 bytes so every lane index is in range.
    localparam logic [255:0] HDR_PAD = {EXP_DST_MAC, EXP_SRC_MAC, ETH_TYPE, PAYLOAD, 80'h0};

    typedef enum logic [2:0] {ST_B0, ST_B1, ST_B2, ST_B3, ST_TAIL} state_t;
    typedef enum logic [1:0] {CLS_GOOD, CLS_BAD, CLS_FOREIGN, CLS_ERR} cls_t;

    // Expected tdata for a given beat: frame byte n sits on lane n%8.
    function automatic logic [63:0] exp_beat(input int beat);
        logic [63:0] v;
        v = '0;
        for (int l = 0; l < 8; l++) begin
            v[8*l +: 8] = HDR_PAD[255 - 8*(8*beat + l) -: 8];
        end
        return v;
    endfunction

    // Bit mask covering the lanes of a beat that carry frame bytes [lo, hi).
    function automatic logic [63:0] lane_mask(input int beat, input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int l = 0; l < 8; l++) begin
            if ((8*beat + l) >= lo && (8*beat + l) < hi) begin
                m[8*l +: 8] = 8'hff;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/nf_pktchk_if.sv
// MAC RX AXI-Stream beat bundle; the MAC drives it, the checker only observes.
interface nf_pktchk_if;
    logic        m_axis_rx_tvalid;
    logic [63:0] m_axis_rx_tdata;
    logic [7:0]  m_axis_rx_tkeep;
    logic        m_axis_rx_tlast;
    logic        m_axis_rx_tuser;

    modport master (
        output m_axis_rx_tvalid, m_axis_rx_tdata, m_axis_rx_tkeep,
               m_axis_rx_tlast, m_axis_rx_tuser
    );
    modport slave (
        input  m_axis_rx_tvalid, m_axis_rx_tdata, m_axis_rx_tkeep,
               m_axis_rx_tlast, m_axis_rx_tuser
    );
endinterface

// File: rtl/nf_pktchk_seq.sv
// Sequence tracker: expected-seq bookkeeping, lost/reorder counters, last good seq.
// Latency: outputs update on the edge that samples i_good.
// Backpressure: none; one update per strobe.
module nf_pktchk_seq (
    input  logic        clk156,
    input  logic        reset,
    input  logic        i_good,
    input  logic [31:0] i_seq,
    output logic [31:0] o_last_seq,
    output logic [31:0] o_cnt_lost,
    output logic [31:0] o_cnt_reorder,
    output logic        o_seq_valid
);
    logic [31:0] r_exp_seq;
    logic [31:0] r_last_seq;
    logic [31:0] r_cnt_lost;
    logic [31:0] r_cnt_reorder;
    logic        r_seq_valid;
    logic [31:0] w_delta;

    assign w_delta = i_seq - r_exp_seq;

    // A "negative" modular distance means the frame is older than expected.
    always_ff @(posedge clk156) begin
        if (reset) begin
            r_exp_seq     <= '0;
            r_last_seq    <= '0;
            r_cnt_lost    <= '0;
            r_cnt_reorder <= '0;
            r_seq_valid   <= 1'b0;
        end else if (i_good) begin
            r_last_seq <= i_seq;
            if (!r_seq_valid) begin
                r_seq_valid <= 1'b1;
                r_exp_seq   <= i_seq + 32'd1;
            end else if (w_delta[31]) begin
                r_cnt_reorder <= r_cnt_reorder + 32'd1;
            end else begin
                r_cnt_lost <= r_cnt_lost + w_delta;
                r_exp_seq  <= i_seq + 32'd1;
            end
        end
    end

    assign o_last_seq    = r_last_seq;
    assign o_cnt_lost    = r_cnt_lost;
    assign o_cnt_reorder = r_cnt_reorder;
    assign o_seq_valid   = r_seq_valid;
endmodule

// File: rtl/nf_pktchk.sv
// RX test-frame checker: parses header/seq, classifies and counts every frame.
// Latency: counters, frame_done and seq status update one cycle after the tlast beat.
// Backpressure: none; every valid beat is consumed in the cycle it appears.
module nf_pktchk
    import nf_pkt_pkg::*;
(
    input  logic        clk156,
    input  logic        reset,
    nf_pktchk_if.slave  rx,
    output logic        frame_done,
    output logic [31:0] cnt_good,
    output logic [31:0] cnt_bad,
    output logic [31:0] cnt_foreign,
    output logic [31:0] cnt_err,
    output logic [31:0] cnt_lost,
    output logic [31:0] cnt_reorder,
    output logic [31:0] last_seq,
    output logic        seq_valid
);
    localparam logic [63:0] EXP_B0  = exp_beat(0);
    localparam logic [63:0] EXP_B1  = exp_beat(1);
    localparam logic [63:0] EXP_B2  = exp_beat(2);
    localparam logic [63:0] M_DST0  = lane_mask(0, OFF_DST, OFF_SRC);
    localparam logic [63:0] M_SRC0  = lane_mask(0, OFF_SRC, OFF_TYPE);
    localparam logic [63:0] M_SRC1  = lane_mask(1, OFF_SRC, OFF_TYPE);
    localparam logic [63:0] M_TYPE1 = lane_mask(1, OFF_TYPE, OFF_PAY);
    localparam logic [63:0] M_PAY1  = lane_mask(1, OFF_PAY, OFF_SEQ);
    localparam logic [63:0] M_PAY2  = lane_mask(2, OFF_PAY, OFF_SEQ);
    localparam int          SEQ_LANE = OFF_SEQ % 8;
    // tkeep lanes that must be present: last EtherType byte on beat 1, last seq byte on beat 3.
    localparam logic [7:0]  KEEP_TYPE = 8'(1 << ((OFF_TYPE + 1) % 8));
    localparam logic [7:0]  KEEP_MIN  = 8'((1 << (((MIN_LEN - 1) % 8) + 1)) - 1);

    state_t      r_state;
    logic        r_dst_bad, r_src_bad, r_type_bad, r_pay_bad;
    logic [15:0] r_seq_hi, r_seq_lo;
    logic        r_frame_done;
    logic [31:0] r_cnt_good, r_cnt_bad, r_cnt_foreign, r_cnt_err;

    logic        w_beat, w_last, w_first, w_good;
    logic        w_dst_f, w_src_f, w_type_f, w_pay_f, w_short_fgn, w_short_bad;
    logic [63:0] w_dat;
    logic [7:0]  w_keep;
    logic [31:0] w_seq;
    cls_t        w_cls;

    assign w_beat = rx.m_axis_rx_tvalid;
    assign w_last = rx.m_axis_rx_tvalid & rx.m_axis_rx_tlast;
    assign w_dat  = rx.m_axis_rx_tdata;
    assign w_keep = rx.m_axis_rx_tkeep;

    // Mismatch flags seen so far including this beat; B0 starts from clean flags.
    always_comb begin
        w_first  = (r_state == ST_B0);
        w_dst_f  = ~w_first & r_dst_bad;
        w_src_f  = ~w_first & r_src_bad;
        w_type_f = ~w_first & r_type_bad;
        w_pay_f  = ~w_first & r_pay_bad;
        case (r_state)
            ST_B0: begin
                w_dst_f = |((w_dat ^ EXP_B0) & M_DST0);
                w_src_f = |((w_dat ^ EXP_B0) & M_SRC0);
            end
            ST_B1: begin
                w_src_f  = w_src_f | (|((w_dat ^ EXP_B1) & M_SRC1));
                w_type_f = |((w_dat ^ EXP_B1) & M_TYPE1);
                w_pay_f  = |((w_dat ^ EXP_B1) & M_PAY1);
            end
            ST_B2: w_pay_f = w_pay_f | (|((w_dat ^ EXP_B2) & M_PAY2));
            default: ;
        endcase

        w_short_fgn = w_first | ((r_state == ST_B1) & ~(&(w_keep | ~KEEP_TYPE)));
        w_short_bad = ((r_state != ST_B3) & (r_state != ST_TAIL))
                    | ((r_state == ST_B3) & ~(&(w_keep | ~KEEP_MIN)));

        if (!rx.m_axis_rx_tuser)                          w_cls = CLS_ERR;
        else if (w_short_fgn | w_dst_f | w_type_f)        w_cls = CLS_FOREIGN;
        else if (w_short_bad | w_src_f | w_pay_f)         w_cls = CLS_BAD;
        else                                              w_cls = CLS_GOOD;

        w_seq  = (r_state == ST_B3) ? {r_seq_hi, w_dat[7:0], w_dat[15:8]}
                                    : {r_seq_hi, r_seq_lo};
        w_good = w_last & (w_cls == CLS_GOOD);
    end

    always_ff @(posedge clk156) begin
        if (reset) begin
            r_state       <= ST_B0;
            r_dst_bad     <= 1'b0;
            r_src_bad     <= 1'b0;
            r_type_bad    <= 1'b0;
            r_pay_bad     <= 1'b0;
            r_seq_hi      <= '0;
            r_seq_lo      <= '0;
            r_frame_done  <= 1'b0;
            r_cnt_good    <= '0;
            r_cnt_bad     <= '0;
            r_cnt_foreign <= '0;
            r_cnt_err     <= '0;
        end else begin
            r_frame_done <= w_last;
            if (w_beat) begin
                r_dst_bad  <= w_dst_f;
                r_src_bad  <= w_src_f;
                r_type_bad <= w_type_f;
                r_pay_bad  <= w_pay_f;
                if (r_state == ST_B2) r_seq_hi <= {w_dat[8*SEQ_LANE +: 8], w_dat[8*SEQ_LANE + 8 +: 8]};
                if (r_state == ST_B3) r_seq_lo <= {w_dat[7:0], w_dat[15:8]};
                if (w_last) begin
                    r_state <= ST_B0;
                end else begin
                    case (r_state)
                        ST_B0:   r_state <= ST_B1;
                        ST_B1:   r_state <= ST_B2;
                        ST_B2:   r_state <= ST_B3;
                        default: r_state <= ST_TAIL;
                    endcase
                end
            end
            if (w_last) begin
                case (w_cls)
                    CLS_GOOD:    r_cnt_good    <= r_cnt_good + 32'd1;
                    CLS_BAD:     r_cnt_bad     <= r_cnt_bad + 32'd1;
                    CLS_FOREIGN: r_cnt_foreign <= r_cnt_foreign + 32'd1;
                    default:     r_cnt_err     <= r_cnt_err + 32'd1;
                endcase
            end
        end
    end

    nf_pktchk_seq u_seq (
        .clk156        (clk156),
        .reset         (reset),
        .i_good        (w_good),
        .i_seq         (w_seq),
        .o_last_seq    (last_seq),
        .o_cnt_lost    (cnt_lost),
        .o_cnt_reorder (cnt_reorder),
        .o_seq_valid   (seq_valid)
    );

    assign frame_done  = r_frame_done;
    assign cnt_good    = r_cnt_good;
    assign cnt_bad     = r_cnt_bad;
    assign cnt_foreign = r_cnt_foreign;
    assign cnt_err     = r_cnt_err;
endmodule

// File: tb/tb_nf_pktchk.sv
// Randomised scoreboard bench for nf_pktchk with a frame-level reference model.
module tb_nf_pktchk;
    localparam logic [175:0] T_HDR = {48'h3ca9f457afde, 48'h3ca9f457aade, 16'h0800, 64'hf00dfaced066f00d};

    typedef logic [7:0] u8_t;
    typedef struct {
        logic [31:0] good, bad, fgn, err, lost, reo, last;
        logic        sv;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_done, seq_valid;
    logic [31:0] cnt_good, cnt_bad, cnt_foreign, cnt_err, cnt_lost, cnt_reorder, last_seq;

    nf_pktchk_if rx_if ();

    nf_pktchk dut (
        .clk156      (clk),
        .reset       (reset),
        .rx          (rx_if),
        .frame_done  (frame_done),
        .cnt_good    (cnt_good),
        .cnt_bad     (cnt_bad),
        .cnt_foreign (cnt_foreign),
        .cnt_err     (cnt_err),
        .cnt_lost    (cnt_lost),
        .cnt_reorder (cnt_reorder),
        .last_seq    (last_seq),
        .seq_valid   (seq_valid)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_done = 0;
    exp_t exp_q[$];
    u8_t  fr[$];

    logic [31:0] m_good, m_bad, m_fgn, m_err, m_lost, m_reo, m_last, m_exp;
    logic        m_sv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        m_good = 0; m_bad = 0; m_fgn = 0; m_err = 0;
        m_lost = 0; m_reo = 0; m_last = 0; m_exp = 0; m_sv = 1'b0;
    endtask

    // Classify the frame in fr[] from its bytes and length, then queue the expected status.
    task automatic model_frame(input bit tuser);
        int          len = fr.size();
        logic [175:0] h = T_HDR;
        bit          dst_ok = 1, src_ok = 1, type_ok = 1, pay_ok = 1;
        logic [31:0] seq, d;
        exp_t        e;
        for (int i = 0; i < 22 && i < len; i++) begin
            if (fr[i] !== h[175 - 8*i -: 8]) begin
                if (i < 6)       dst_ok = 0;
                else if (i < 12) src_ok = 0;
                else if (i < 14) type_ok = 0;
                else             pay_ok = 0;
            end
        end
        if (!tuser) m_err++;
        else if (len < 14 || !dst_ok || !type_ok) m_fgn++;
        else if (len < 26 || !src_ok || !pay_ok) m_bad++;
        else begin
            m_good++;
            seq = {fr[22], fr[23], fr[24], fr[25]};
            m_last = seq;
            if (!m_sv) begin
                m_sv = 1'b1;
                m_exp = seq + 1;
            end else begin
                d = seq - m_exp;
                if (d >= 32'h8000_0000) m_reo++;
                else begin
                    m_lost += d;
                    m_exp = seq + 1;
                end
            end
        end
        e.good = m_good; e.bad = m_bad; e.fgn = m_fgn; e.err = m_err;
        e.lost = m_lost; e.reo = m_reo; e.last = m_last; e.sv = m_sv;
        exp_q.push_back(e);
    endtask

    task automatic build_frame(input int len, input logic [31:0] seq);
        logic [175:0] h = T_HDR;
        fr.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 22)      fr.push_back(h[175 - 8*i -: 8]);
            else if (i < 26) fr.push_back(seq[31 - 8*(i-22) -: 8]);
            else             fr.push_back(u8_t'($urandom));
        end
    endtask

    task automatic drive_beat(input int b, input bit tuser);
        int nb = (fr.size() + 7) / 8;
        for (int l = 0; l < 8; l++) begin
            if (8*b + l < fr.size()) begin
                rx_if.m_axis_rx_tdata[8*l +: 8] = fr[8*b + l];
                rx_if.m_axis_rx_tkeep[l] = 1'b1;
            end else begin
                rx_if.m_axis_rx_tdata[8*l +: 8] = u8_t'($urandom);
                rx_if.m_axis_rx_tkeep[l] = 1'b0;
            end
        end
        rx_if.m_axis_rx_tvalid = 1'b1;
        rx_if.m_axis_rx_tlast  = (b == nb - 1);
        rx_if.m_axis_rx_tuser  = (b == nb - 1) ? tuser : 1'(($urandom));
    endtask

    task automatic idle_bus();
        rx_if.m_axis_rx_tvalid = 1'b0;
        rx_if.m_axis_rx_tlast  = 1'b0;
    endtask

    task automatic send_frame(input bit tuser, input int gap, input bit idles);
        int nb = (fr.size() + 7) / 8;
        model_frame(tuser);
        for (int b = 0; b < nb; b++) begin
            if (idles && $urandom_range(0, 3) == 0) begin
                idle_bus();
                @(posedge clk); #1;
            end
            drive_beat(b, tuser);
            @(posedge clk); #1;
        end
        idle_bus();
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_done"}, {31'd0, frame_done}, 0);
        chk({tag, "_good"}, cnt_good, 0);
        chk({tag, "_bad"}, cnt_bad, 0);
        chk({tag, "_fgn"}, cnt_foreign, 0);
        chk({tag, "_err"}, cnt_err, 0);
        chk({tag, "_lost"}, cnt_lost, 0);
        chk({tag, "_reo"}, cnt_reorder, 0);
        chk({tag, "_last"}, last_seq, 0);
        chk({tag, "_sv"}, {31'd0, seq_valid}, 0);
    endtask

    // Monitor: every frame_done pulse must match the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL frame_done: got unexpected pulse, required none");
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_good", cnt_good, e.good);
                    chk("sb_bad", cnt_bad, e.bad);
                    chk("sb_fgn", cnt_foreign, e.fgn);
                    chk("sb_err", cnt_err, e.err);
                    chk("sb_lost", cnt_lost, e.lost);
                    chk("sb_reo", cnt_reorder, e.reo);
                    chk("sb_last", last_seq, e.last);
                    chk("sb_sv", {31'd0, seq_valid}, {31'd0, e.sv});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, len;
        logic [31:0] s;
        rx_if.m_axis_rx_tvalid = 1'b0;
        rx_if.m_axis_rx_tdata  = '0;
        rx_if.m_axis_rx_tkeep  = '0;
        rx_if.m_axis_rx_tlast  = 1'b0;
        rx_if.m_axis_rx_tuser  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_zero("rst");

        // In-order good frames
        d0 = n_done;
        for (int i = 0; i < 3; i++) begin
            build_frame(26, i);
            send_frame(1'b1, 1, 1'b0);
        end
        wait_idle();
        chk("inorder_good", cnt_good, 3);
        chk("inorder_lost", cnt_lost, 0);
        chk("inorder_last", last_seq, 2);
        chk("inorder_pulses", n_done - d0, 3);

        // Gap then reorder, then the expected-next value
        do_reset();
        build_frame(26, 5); send_frame(1'b1, 2, 1'b1);
        build_frame(26, 9); send_frame(1'b1, 0, 1'b1);
        build_frame(26, 7); send_frame(1'b1, 3, 1'b1);
        wait_idle();
        chk("gap_good", cnt_good, 3);
        chk("gap_lost", cnt_lost, 3);
        chk("gap_reo", cnt_reorder, 1);
        chk("gap_last", last_seq, 7);
        build_frame(26, 10); send_frame(1'b1, 1, 1'b0);
        wait_idle();
        chk("next10_lost", cnt_lost, 3);
        chk("next10_good", cnt_good, 4);

        // Class coverage
        do_reset();
        build_frame(26, 0); send_frame(1'b0, 1, 1'b0);
        build_frame(26, 0); fr[0] = 8'h00; send_frame(1'b1, 1, 1'b0);
        build_frame(26, 0); fr[15] = fr[15] ^ 8'hff; send_frame(1'b1, 1, 1'b0);
        build_frame(22, 0); send_frame(1'b1, 1, 1'b0);
        build_frame(6, 0); send_frame(1'b1, 0, 1'b0);
        wait_idle();
        chk("cls_err", cnt_err, 1);
        chk("cls_fgn", cnt_foreign, 2);
        chk("cls_bad", cnt_bad, 2);
        chk("cls_good", cnt_good, 0);
        chk("cls_sv", {31'd0, seq_valid}, 0);

        // Padded frame
        build_frame(60, 0); send_frame(1'b1, 1, 1'b1);
        wait_idle();
        chk("pad_good", cnt_good, 1);
        chk("pad_sv", {31'd0, seq_valid}, 1);

        // Back-to-back with sequence wrap
        do_reset();
        build_frame(26, 32'hFFFF_FFFF); send_frame(1'b1, 0, 1'b0);
        build_frame(26, 0); send_frame(1'b1, 0, 1'b0);
        wait_idle();
        chk("wrap_good", cnt_good, 2);
        chk("wrap_lost", cnt_lost, 0);
        chk("wrap_last", last_seq, 0);

        // Reset during beat 2 discards the partial frame
        build_frame(26, 3);
        drive_beat(0, 1'b1); @(posedge clk); #1;
        drive_beat(1, 1'b1); @(posedge clk); #1;
        drive_beat(2, 1'b1); reset = 1'b1; @(posedge clk); #1;
        reset = 1'b0; idle_bus(); model_reset();
        @(negedge clk);
        chk_zero("midrst");
        build_frame(26, 1); send_frame(1'b1, 1, 1'b0);
        wait_idle();
        chk("midrst_good", cnt_good, 1);

        // Reset coinciding with tlast wins
        build_frame(26, 2);
        for (int b = 0; b < 3; b++) begin drive_beat(b, 1'b1); @(posedge clk); #1; end
        drive_beat(3, 1'b1); reset = 1'b1; @(posedge clk); #1;
        reset = 1'b0; idle_bus(); model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rstlast_good", cnt_good, 0);
        chk("rstlast_sv", {31'd0, seq_valid}, 0);

        // Randomised traffic
        for (int f = 0; f < 150; f++) begin
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 25)) : int'($urandom_range(26, 72));
            s = ($urandom_range(0, 9) == 9) ? $urandom : m_exp + $urandom_range(0, 6) - 32'd3;
            build_frame(len, s);
            if ($urandom_range(0, 3) == 0) begin
                int p = $urandom_range(0, 25);
                if (p < len) fr[p] = fr[p] ^ u8_t'($urandom_range(1, 255));
            end
            send_frame($urandom_range(0, 9) != 0, $urandom_range(0, 2), 1'b1);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/nf_pktchk.md
# nf_pktchk

Receive-side packet checker for the 10G Ethernet MAC AXI-Stream RX interface on the 156.25 MHz clock domain. Parses each received frame and checks it against the fixed test-frame format sent by our packet generator: destination MAC, source MAC, EtherType, 8-byte payload and 32-bit sequence number. Classifies every frame and counts it as good, bad, foreign or errored. Tracks sequence numbers to count lost and reordered frames, and exposes all counters as status for the rest of the network function.

## Interface
- EXP_DST_MAC, 48'h3ca9f457afde: expected frame bytes 0–5
- EXP_SRC_MAC, 48'h3ca9f457aade: expected frame bytes 6–11
- ETH_TYPE, 16'h0800: expected bytes 12–13
- PAYLOAD, 64'hf00d_face_d066_f00d: expected bytes 14–21
- clk156  in  1  156.25 MHz clock; sole clock
- reset  in  1  synchronous, active-high
- m_axis_rx_tvalid  in  1  beat valid; no tready, and the MAC cannot be stalled
- m_axis_rx_tdata  in  64  frame byte n on lane n%8, i.e. tdata[8*(n%8)+7 : 8*(n%8)]
- m_axis_rx_tkeep  in  8  byte enables; all ones on every non-last beat
- m_axis_rx_tlast  in  1  last beat of frame
- m_axis_rx_tuser  in  1  sampled with tlast; 1 = good frame (FCS ok), 0 = errored
- frame_done  out  1  one-cycle pulse per classified frame
- cnt_good, cnt_bad, cnt_foreign, cnt_err  out  32 each  frame class counters
- cnt_lost, cnt_reorder  out  32 each  sequence statistics
- last_seq  out  32  sequence number of the most recent good frame
- seq_valid  out  1  at least one good frame received since reset

## Operation
- Frame layout: bytes 22–25 hold the sequence number, big-endian (byte 22 = MSB).
  - Beat 3 carries bytes 24–25 on tkeep[1:0].
  - Longer (MAC-padded) frames are legal; bytes 26 and up are ignored.
- FSM states:
  - B0: expecting beat 0; reset state.
  - B1, B2, B3: expecting beats 1–3.
  - TAIL: drains beats until tlast.
- Transitions:
  - Each valid beat advances B0→B1→B2→B3→TAIL.
  - Valid tlast in any state returns to B0.
  - With tvalid low, the FSM holds its state.
- Per-field mismatch flags are set on the beat that carries the field and cleared in B0 when a new frame starts.
- Sequence bytes are captured on beats 2 and 3.
- Classification on the tlast beat, highest priority first:
  1. err: tuser = 0.
  2. foreign: frame ends before byte 13, or dst MAC mismatch, or EtherType mismatch.
  3. bad: src MAC or payload mismatch, or frame ends before byte 25 (tlast in B0/B1/B2, or in B3 with tkeep[1:0] ≠ 2'b11).
  4. good: everything else.
- Exactly one class counter increments per frame.
- Sequence tracking, good frames only, with d = seq − exp_seq mod 2^32:
  - First good frame after reset: exp_seq = seq+1, seq_valid = 1, no loss counted.
  - d == 0: exp_seq = seq+1.
  - d[31] == 0 and d ≠ 0: cnt_lost += d, then exp_seq = seq+1.
  - d[31] == 1: cnt_reorder += 1, exp_seq unchanged.
  - last_seq = seq for every good frame.
- All counters wrap modulo 2^32. All arithmetic is unsigned 32-bit.

## Timing
- Reset values:
  - All counters 0, last_seq 0, seq_valid 0, frame_done 0.
  - FSM in B0; internal exp_seq 0.
- Latency: frame_done, the class counters and the sequence outputs update in the cycle after the tlast beat (one register stage).
- Back-to-back frames: beat 0 of the next frame may arrive in the cycle right after tlast and must be parsed correctly.
- A single-beat frame (tlast in B0) is legal and is classified foreign.
- Reset mid-frame:
  - The partial frame is discarded and not counted.
  - If reset is released mid-frame, the remaining beats are parsed as a new frame; this is accepted behaviour.
- Reset has priority over a simultaneous tlast: the frame is not counted.

## Structure
- Shared package nf_pkt_pkg holds:
  - frame byte offsets (DST 0, SRC 6, TYPE 12, PAYLOAD 14, SEQ 22, MIN_LEN 26)
  - default MAC/EtherType/payload constants
  - the FSM state enum
  - the frame-class enum
- Sub-module nf_pktchk_seq owns exp_seq, seq_valid, last_seq, cnt_lost and cnt_reorder.
  - Inputs: a good-frame strobe and the 32-bit seq.

## Test plan
- Good frames in order: three default 26-byte frames, seq 0, 1, 2 → cnt_good = 3, cnt_lost = 0, last_seq = 2, three frame_done pulses.
- Gap then reorder: frames with seq 5, 9, 7 → cnt_good = 3, cnt_lost = 3, cnt_reorder = 1, last_seq = 7, next expected seq 10.
- Classes:
  - frame with tuser = 0 → cnt_err = 1
  - dst byte 0 = 8'h00 → cnt_foreign = 1
  - payload byte 15 flipped → cnt_bad = 1
  - 22-byte frame (tlast in B2, tkeep 8'h3F) → cnt_bad = 1
- Padded frame: 60-byte frame with a correct header and seq 0 → good; the extra beats are ignored.
- Back-to-back frames with no idle cycle, plus a wrap: seq 32'hFFFFFFFF then seq 0 → cnt_lost = 0, cnt_good = 2.
- Reset asserted during beat 2 of a frame → all outputs 0 the next cycle; a following clean frame counts cnt_good = 1.
